// File: rtl/ds_frame_ctrl.sv
// Frame-level sequencer for the 3:1 downscaler: checks active geometry per frame,
// generates x/y decimation phases and the output-sample strobe, and gates the datapath.
module ds_frame_ctrl #(
  parameter int HACT   = 10,
  parameter int VACT   = 10,
  parameter int FACTOR = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_vsync,
  input  logic                         i_hsync,
  input  logic                         i_de,
  input  logic                         cfg_en,
  input  logic                         cfg_bypass,
  input  logic                         err_clr,
  output logic [1:0]                   o_state,
  output logic                         o_run,
  output logic                         o_bypass,
  output logic [$clog2(FACTOR)-1:0]    o_x_phase,
  output logic [$clog2(FACTOR)-1:0]    o_y_phase,
  output logic                         o_sample,
  output logic [$clog2(HACT+1)-1:0]    o_pix_cnt,
  output logic [$clog2(VACT+1)-1:0]    o_line_cnt,
  output logic                         o_frame_err
);

  localparam int XW = $clog2(FACTOR);
  localparam int PW = $clog2(HACT + 1);
  localparam int LW = $clog2(VACT + 1);

  localparam logic [XW-1:0] X_LAST = XW'(FACTOR - 1);
  localparam logic [PW-1:0] HACT_C = PW'(HACT);
  localparam logic [LW-1:0] VACT_C = LW'(VACT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t          state_r;
  logic            run_r;
  logic            bypass_r;
  logic [XW-1:0]   x_phase_r;
  logic [XW-1:0]   y_phase_r;
  logic [PW-1:0]   pix_cnt_r;
  logic [LW-1:0]   line_cnt_r;
  logic            frame_err_r;
  logic            vsync_q_r;
  logic            de_q_r;

  logic            v_r_s;
  logic            d_f_s;
  logic            err_s;
  logic [LW-1:0]   line_inc_s;
  logic            hsync_unused_s;

  function automatic logic [XW-1:0] phase_inc(input logic [XW-1:0] p);
    return (p == X_LAST) ? '0 : p + XW'(1);
  endfunction

  assign hsync_unused_s = i_hsync;
  assign v_r_s          = i_vsync & ~vsync_q_r;
  assign d_f_s          = ~i_de & de_q_r;
  assign line_inc_s     = line_cnt_r + LW'(1);

  // Geometry error detection; a line end coinciding with frame start is counted before the frame check
  always_comb begin
    err_s = 1'b0;
    if (state_r == S_RUN) begin
      if (i_de && (pix_cnt_r == HACT_C)) begin
        err_s = 1'b1;
      end else if (d_f_s && ((pix_cnt_r != HACT_C) || (line_cnt_r == VACT_C))) begin
        err_s = 1'b1;
      end else if (v_r_s && ((d_f_s ? line_inc_s : line_cnt_r) != VACT_C)) begin
        err_s = 1'b1;
      end else begin
        err_s = 1'b0;
      end
    end else begin
      err_s = 1'b0;
    end
  end

  // Frame sequencer with edge detectors, counters, phases and registered status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= S_IDLE;
      run_r       <= 1'b0;
      bypass_r    <= 1'b0;
      x_phase_r   <= '0;
      y_phase_r   <= '0;
      pix_cnt_r   <= '0;
      line_cnt_r  <= '0;
      frame_err_r <= 1'b0;
      vsync_q_r   <= 1'b0;
      de_q_r      <= 1'b0;
    end else begin
      vsync_q_r   <= i_vsync;
      de_q_r      <= i_de;
      frame_err_r <= err_s | (frame_err_r & ~err_clr);
      case (state_r)
        S_IDLE: begin
          run_r      <= 1'b0;
          x_phase_r  <= '0;
          y_phase_r  <= '0;
          pix_cnt_r  <= '0;
          line_cnt_r <= '0;
          if (cfg_en) begin
            state_r <= S_ARM;
          end
        end
        S_ARM: begin
          if (!cfg_en) begin
            state_r <= S_IDLE;
          end else if (v_r_s) begin
            state_r    <= S_RUN;
            run_r      <= 1'b1;
            bypass_r   <= cfg_bypass;
            x_phase_r  <= '0;
            y_phase_r  <= '0;
            pix_cnt_r  <= '0;
            line_cnt_r <= '0;
          end
        end
        S_RUN: begin
          if (err_s) begin
            state_r    <= S_ERR;
            run_r      <= 1'b0;
            x_phase_r  <= '0;
            y_phase_r  <= '0;
            pix_cnt_r  <= '0;
            line_cnt_r <= '0;
          end else if (v_r_s) begin
            x_phase_r  <= '0;
            y_phase_r  <= '0;
            pix_cnt_r  <= '0;
            line_cnt_r <= '0;
            if (cfg_en) begin
              bypass_r <= cfg_bypass;
            end else begin
              state_r  <= S_IDLE;
              run_r    <= 1'b0;
            end
          end else if (i_de) begin
            pix_cnt_r <= pix_cnt_r + PW'(1);
            x_phase_r <= phase_inc(x_phase_r);
          end else if (d_f_s) begin
            pix_cnt_r  <= '0;
            x_phase_r  <= '0;
            line_cnt_r <= line_inc_s;
            y_phase_r  <= phase_inc(y_phase_r);
          end
        end
        S_ERR: begin
          run_r <= 1'b0;
          if (v_r_s) begin
            if (cfg_en) begin
              state_r  <= S_RUN;
              run_r    <= 1'b1;
              bypass_r <= cfg_bypass;
            end else begin
              state_r  <= S_IDLE;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          run_r   <= 1'b0;
        end
      endcase
    end
  end

  assign o_state     = state_r;
  assign o_run       = run_r;
  assign o_bypass    = bypass_r;
  assign o_x_phase   = x_phase_r;
  assign o_y_phase   = y_phase_r;
  assign o_pix_cnt   = pix_cnt_r;
  assign o_line_cnt  = line_cnt_r;
  assign o_frame_err = frame_err_r;
  assign o_sample    = run_r & i_de & (x_phase_r == X_LAST) & (y_phase_r == X_LAST);

endmodule

// File: tb/tb_ds_frame_ctrl.sv
// Directed bench for ds_frame_ctrl: frame-level model compared every cycle,
// plus hand-computed checkpoints for states, flags and sample positions.
module tb_ds_frame_ctrl;
  localparam int H = 6;
  localparam int V = 6;
  localparam int F = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_vsync = 1'b0;
  logic i_hsync = 1'b0;
  logic i_de = 1'b0;
  logic cfg_en = 1'b0;
  logic cfg_bypass = 1'b0;
  logic err_clr = 1'b0;
  logic [1:0] o_state;
  logic o_run;
  logic o_bypass;
  logic [$clog2(F)-1:0] o_x_phase;
  logic [$clog2(F)-1:0] o_y_phase;
  logic o_sample;
  logic [$clog2(H+1)-1:0] o_pix_cnt;
  logic [$clog2(V+1)-1:0] o_line_cnt;
  logic o_frame_err;

  ds_frame_ctrl #(.HACT(H), .VACT(V), .FACTOR(F)) dut (
    .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
    .cfg_en(cfg_en), .cfg_bypass(cfg_bypass), .err_clr(err_clr),
    .o_state(o_state), .o_run(o_run), .o_bypass(o_bypass),
    .o_x_phase(o_x_phase), .o_y_phase(o_y_phase), .o_sample(o_sample),
    .o_pix_cnt(o_pix_cnt), .o_line_cnt(o_line_cnt), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cur_row = 0;
  int cur_col = 0;
  int sample_q[$];
  int exp_pos[4] = '{34, 37, 82, 85};

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Frame-level model: mode 0 idle, 1 armed, 2 running, 3 error
  int m_mode = 0, m_pix = 0, m_line = 0;
  bit m_byp = 1'b0, m_err = 1'b0, m_pvs = 1'b0, m_pde = 1'b0;
  int n_mode, n_pix, n_line, lines_done;
  bit n_byp, bad, vr, df;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode <= 0; m_pix <= 0; m_line <= 0;
      m_byp <= 1'b0; m_err <= 1'b0; m_pvs <= 1'b0; m_pde <= 1'b0;
    end else begin
      n_mode = m_mode; n_pix = m_pix; n_line = m_line; n_byp = m_byp;
      vr = i_vsync && !m_pvs;
      df = !i_de && m_pde;
      bad = 1'b0;
      case (m_mode)
        0: if (cfg_en) n_mode = 1;
        1: begin
          if (!cfg_en) n_mode = 0;
          else if (vr) begin n_mode = 2; n_byp = cfg_bypass; n_pix = 0; n_line = 0; end
        end
        2: begin
          if (i_de && m_pix == H) bad = 1'b1;
          if (df && (m_pix != H || m_line == V)) bad = 1'b1;
          lines_done = m_line + (df ? 1 : 0);
          if (vr && lines_done != V) bad = 1'b1;
          if (bad) begin n_mode = 3; n_pix = 0; n_line = 0; end
          else if (vr) begin
            n_pix = 0; n_line = 0;
            if (cfg_en) n_byp = cfg_bypass;
            else n_mode = 0;
          end
          else if (i_de) n_pix = m_pix + 1;
          else if (df) begin n_pix = 0; n_line = m_line + 1; end
        end
        3: if (vr) begin
          if (cfg_en) begin n_mode = 2; n_byp = cfg_bypass; end
          else n_mode = 0;
        end
        default: ;
      endcase
      m_mode <= n_mode; m_pix <= n_pix; m_line <= n_line; m_byp <= n_byp;
      m_err <= bad || (m_err && !err_clr);
      m_pvs <= i_vsync; m_pde <= i_de;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("state", int'(o_state), m_mode);
    chk("run", int'(o_run), int'(m_mode == 2));
    chk("bypass", int'(o_bypass), int'(m_byp));
    chk("x_phase", int'(o_x_phase), m_pix % F);
    chk("y_phase", int'(o_y_phase), m_line % F);
    chk("pix_cnt", int'(o_pix_cnt), m_pix);
    chk("line_cnt", int'(o_line_cnt), m_line);
    chk("frame_err", int'(o_frame_err), int'(m_err));
    chk("sample", int'(o_sample),
        int'(m_mode == 2 && i_de && (m_pix % F) == F - 1 && (m_line % F) == F - 1));
    if (o_sample) sample_q.push_back(cur_row * 16 + cur_col);
  end

  task automatic tick(input logic vs, input logic de);
    i_vsync = vs;
    i_de = de;
    @(posedge clk);
    #2;
  endtask

  task automatic vpulse();
    sample_q.delete();
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
  endtask

  // act: 1 raise cfg_bypass, 2 drop cfg_en, 3 pulse err_clr, at the start of line act_line
  task automatic body(input int nlines, input int short_line, input bit clr_df,
                      input int act_line, input int act);
    for (int r = 0; r < nlines; r++) begin
      cur_row = r;
      if (r == act_line) begin
        case (act)
          1: cfg_bypass = 1'b1;
          2: cfg_en = 1'b0;
          3: begin err_clr = 1'b1; tick(1'b0, 1'b0); err_clr = 1'b0; end
          default: ;
        endcase
      end
      for (int c = 0; c < ((r == short_line) ? H - 1 : H); c++) begin
        cur_col = c;
        tick(1'b0, 1'b1);
      end
      err_clr = (r == short_line) && clr_df;
      tick(1'b0, 1'b0);
      err_clr = 1'b0;
      tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic chk_samples();
    chk("sample_count", sample_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < sample_q.size()) chk("sample_pos", sample_q[i], exp_pos[i]);
  endtask

  initial begin
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("reset_state", int'(o_state), 0);
    chk("reset_run", int'(o_run), 0);
    chk("reset_err", int'(o_frame_err), 0);
    rstn = 1'b1;
    tick(1'b0, 1'b0);
    chk("idle_hold", int'(o_state), 0);
    cfg_en = 1'b1;
    tick(1'b0, 1'b0);
    chk("arm", int'(o_state), 1);
    vpulse();
    chk("run_after_vr", int'(o_state), 2);
    chk("run_flag", int'(o_run), 1);
    body(6, -1, 1'b0, -1, 0);
    chk_samples();
    vpulse();
    chk("clean_frame1", int'(o_state), 2);
    body(6, -1, 1'b0, -1, 0);
    chk_samples();
    chk("no_err", int'(o_frame_err), 0);
    vpulse();
    body(6, 2, 1'b0, -1, 0);
    chk("short_line_state", int'(o_state), 3);
    chk("short_line_err", int'(o_frame_err), 1);
    chk("short_line_run", int'(o_run), 0);
    vpulse();
    chk("relock", int'(o_state), 2);
    body(6, -1, 1'b0, 1, 3);
    chk("err_cleared", int'(o_frame_err), 0);
    chk_samples();
    vpulse();
    chk("clean_frame2", int'(o_state), 2);
    body(7, -1, 1'b0, -1, 0);
    chk("seven_lines", int'(o_state), 3);
    vpulse();
    chk("relock2", int'(o_state), 2);
    body(5, -1, 1'b0, -1, 0);
    chk("five_lines_pending", int'(o_state), 2);
    vpulse();
    chk("five_lines_err", int'(o_state), 3);
    chk("five_lines_flag", int'(o_frame_err), 1);
    err_clr = 1'b1; tick(1'b0, 1'b0); err_clr = 1'b0;
    chk("err_clr", int'(o_frame_err), 0);
    vpulse();
    chk("relock3", int'(o_state), 2);
    chk("bypass_init", int'(o_bypass), 0);
    body(6, -1, 1'b0, 2, 1);
    chk("bypass_held", int'(o_bypass), 0);
    vpulse();
    chk("bypass_loaded", int'(o_bypass), 1);
    chk("still_run", int'(o_state), 2);
    body(6, -1, 1'b0, 2, 2);
    chk("en_drop_run", int'(o_state), 2);
    vpulse();
    chk("en_drop_idle", int'(o_state), 0);
    chk("en_drop_runflag", int'(o_run), 0);
    cfg_en = 1'b1;
    tick(1'b0, 1'b0);
    chk("rearm", int'(o_state), 1);
    vpulse();
    chk("relock4", int'(o_state), 2);
    chk("bypass_relock", int'(o_bypass), 1);
    body(6, 1, 1'b1, -1, 0);
    chk("set_wins_err", int'(o_frame_err), 1);
    chk("set_wins_state", int'(o_state), 3);
    tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b1);
    rstn = 1'b0;
    tick(1'b1, 1'b1);
    chk("rst_state", int'(o_state), 0);
    chk("rst_bypass", int'(o_bypass), 0);
    chk("rst_pix", int'(o_pix_cnt), 0);
    chk("rst_err", int'(o_frame_err), 0);
    rstn = 1'b1;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    chk("no_lock_high_vsync", int'(o_state), 1);
    chk("no_run_high_vsync", int'(o_run), 0);
    tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    chk("lock_fresh_vr", int'(o_state), 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
